mem_wb_block: RTL and testbench
===============================

# mem_wb_block

- Pipeline stage directly downstream of `EX_Block`.
- Consumes `ans_ex`, `DM_data` and `flag_ex`.
- Performs data-memory access for loads and stores.
- Writes results back into an internal 8×16 register file.
- Provides the combinational register-file read ports that supply `A` and `B` to `EX_Block`, which closes the execute/writeback loop.

## Interface
Parameters:
- `DATA_W`, default 16: datapath width.
- `DM_AW`, default 8: data-memory address bits (256 words).
- `RF_AW`, default 3: register index bits (8 registers).

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `valid_ex`  in  1  EX outputs hold a real instruction this cycle.
- `op_ex`  in  6  opcode that accompanied `ans_ex`.
- `rd_ex`  in  3  destination register index.
- `ans_ex`  in  16  ALU result; this is the effective address for LD/ST.
- `DM_data`  in  16  store data.
- `flag_ex`  in  2  ALU flags.
- `rs1`, `rs2`  in  3 each  read-port indices.
- `A`, `B`  out  16 each  read-port data, combinational.
- `wb_en`  out  1  writeback occurs at next edge.
- `wb_addr`  out  3  writeback register index.
- `wb_data`  out  16  writeback value.
- `flag_reg`  out  2  architectural flags.

## Operation
Opcode classes:
- `op_ex[5]==0` (codes 0–31), ALU op: writes `ans_ex` to `rd_ex` and loads `flag_reg <= flag_ex`.
- `6'b100000` LD: writes `mem[ans_ex[7:0]]` to `rd_ex`; flags unchanged.
- `6'b100001` ST: `mem[ans_ex[7:0]] <= DM_data`; no writeback; flags unchanged.
- All other `op_ex[5]==1` codes are NOP.

Rules:
- When `valid_ex==0`, the input is treated as a NOP.
- Address bits `ans_ex[15:8]` are ignored, so addresses wrap modulo 256.
- R0 reads as 0x0000. A writeback targeting R0 is suppressed: `wb_en` stays 0.
- Read ports use write-through bypass. If `wb_en` is high and `rsN==wb_addr`, then `A`/`B` return `wb_data`; otherwise they return the register-file contents.

## Timing
Two edges, E1 and E2.

At E1:
- M-stage registers capture `valid_ex`, `op_ex`, `rd_ex`, `ans_ex`.
- ST writes the memory.
- LD performs a synchronous read into the memory output register.
- `flag_reg` updates on ALU ops.

Between E1 and E2 (combinational from M-stage):
- `wb_en = m_valid & (ALU|LD) & (m_rd != 0)`.
- `wb_addr = m_rd`.
- `wb_data = LD ? mem_rdata : m_ans`.

At E2:
- The register file is written.
- Result: 1-cycle input-to-`wb_*` latency, 2-edge latency to register-file commit.

Throughput and hazards:
- One instruction per cycle; no stalls.
- ST at cycle N followed by LD of the same address at N+1 returns the new data, because the write completes at N's edge.
- Back-to-back writes to the same `rd` are handled in order; the second one wins.

Reset (`reset==0`):
- Clears M-stage valid, `flag_reg`, and all registers to 0x0000. Consequently `wb_en=0`, `wb_addr=0`, `wb_data=0`, `flag_reg=0`.
- Data memory is not reset.
- Reset mid-operation drops any pending writeback.
- A store that committed at an earlier edge persists.
- Deassertion is asynchronous; the first capture happens at the next rising edge.

## Structure
- Shared package `ex_pkg` holds:
  - `OP_LD` and `OP_ST` constants;
  - an ALU-class test on `op[5]`;
  - the `DATA_W`, `DM_AW`, `RF_AW` widths.
- One sub-module, `data_mem`: 256×16 single-port with synchronous write and synchronous registered read, no reset.
- The register file, bypass and M-stage registers are inline.

## Test plan
- Reset low for 2 cycles, then release: `wb_en=0`, `flag_reg=2'b00`, `A=B=0x0000` for every `rs1`/`rs2`.
- ALU op 0, `rd_ex=3`, `ans_ex=0x1234`, `flag_ex=2'b01`:
  - after E1, `wb_en=1`, `wb_addr=3`, `wb_data=0x1234`, `flag_reg=01`;
  - with `rs1=3`, `A=0x1234` before E2 (bypass) and after E2 (register file).
- ST with `ans_ex=0x0108`, `DM_data=0xBEEF`, then LD `ans_ex=0x0008`, `rd_ex=5` on the next cycle: `wb_data=0xBEEF` one cycle later (address wrap plus store-to-load); `flag_reg` unchanged.
- ALU op with `rd_ex=0`, `ans_ex=0xFFFF`: `wb_en=0`, and `A` with `rs1=0` stays 0x0000.
- Op `6'b100010`, or any op with `valid_ex=0`: no register-file change and no flag change.
- Issue an ALU write to R2, then assert reset between E1 and E2: the R2 write is dropped and `A` for `rs1=2` reads 0x0000 after release; an earlier-stored memory word is still readable.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared widths, opcode constants and opcode-class helpers for the EX/MEM-WB stages.
package ex_pkg;

   localparam int DATA_W = 16;
   localparam int DM_AW  = 8;
   localparam int RF_AW  = 3;
   localparam int OP_W   = 6;

   localparam logic [OP_W-1:0] OP_LD = 6'b100000;
   localparam logic [OP_W-1:0] OP_ST = 6'b100001;

   // Codes 0-31 are ALU operations; the upper half holds memory ops and NOPs.
   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return ~op[OP_W-1];
   endfunction

   function automatic logic is_ld(input logic [OP_W-1:0] op);
      return op == OP_LD;
   endfunction

   function automatic logic is_st(input logic [OP_W-1:0] op);
      return op == OP_ST;
   endfunction

endpackage

// File: rtl/mem_wb_block_data_mem.sv
// Single-port data memory: synchronous write, synchronous registered read, no reset.
module data_mem
   import ex_pkg::*;
#(
   parameter int DW = DATA_W,
   parameter int AW = DM_AW
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/mem_wb_block.sv
// MEM/WB stage: data-memory access, 8x16 register file with write-through read ports,
// and the architectural flag register.
module mem_wb_block
   import ex_pkg::*;
#(
   parameter int DATA_W = ex_pkg::DATA_W,
   parameter int DM_AW  = ex_pkg::DM_AW,
   parameter int RF_AW  = ex_pkg::RF_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_ex,
   input  logic [5:0]        op_ex,
   input  logic [RF_AW-1:0]  rd_ex,
   input  logic [DATA_W-1:0] ans_ex,
   input  logic [DATA_W-1:0] DM_data,
   input  logic [1:0]        flag_ex,
   input  logic [RF_AW-1:0]  rs1,
   input  logic [RF_AW-1:0]  rs2,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   output logic              wb_en,
   output logic [RF_AW-1:0]  wb_addr,
   output logic [DATA_W-1:0] wb_data,
   output logic [1:0]        flag_reg
);

   localparam int NREG = 2**RF_AW;

   logic              m_valid;
   logic [5:0]        m_op;
   logic [RF_AW-1:0]  m_rd;
   logic [DATA_W-1:0] m_ans;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] rf [NREG];

   logic ex_ld, ex_st, ex_alu;

   assign ex_alu = valid_ex & is_alu(op_ex);
   assign ex_ld  = valid_ex & is_ld(op_ex);
   assign ex_st  = valid_ex & is_st(op_ex);

   data_mem #(.DW(DATA_W), .AW(DM_AW)) u_dm (
      .clk   (clk),
      .we    (ex_st),
      .re    (ex_ld),
      .addr  (ans_ex[DM_AW-1:0]),
      .wdata (DM_data),
      .rdata (mem_rdata)
   );

   // M-stage capture; op is cleared to 0 on reset so wb_data settles to m_ans = 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid  <= 1'b0;
         m_op     <= '0;
         m_rd     <= '0;
         m_ans    <= '0;
         flag_reg <= '0;
      end else begin
         m_valid <= valid_ex;
         m_op    <= op_ex;
         m_rd    <= rd_ex;
         m_ans   <= ans_ex;
         if (ex_alu) flag_reg <= flag_ex;
      end
   end

   always_comb begin
      wb_en   = m_valid & (is_alu(m_op) | is_ld(m_op)) & (m_rd != '0);
      wb_addr = m_rd;
      wb_data = is_ld(m_op) ? mem_rdata : m_ans;
   end

   // R0 is never written since wb_en excludes it, so it stays at its reset value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_en) begin
         rf[wb_addr] <= wb_data;
      end
   end

   function automatic logic [DATA_W-1:0] rd_port(input logic [RF_AW-1:0] idx);
      if (idx == '0)                   return '0;
      else if (wb_en && idx == wb_addr) return wb_data;
      else                             return rf[idx];
   endfunction

   always_comb begin
      A = rd_port(rs1);
      B = rd_port(rs2);
   end

endmodule

// File: tb/tb_mem_wb_block.sv
// Directed checks of reset/bypass/wrap/R0 rules plus a randomized stream scored against
// an architectural model (register array, memory array, flags) through an expectation queue.
module tb_mem_wb_block;

   logic        clk, reset, valid_ex;
   logic [5:0]  op_ex;
   logic [2:0]  rd_ex, rs1, rs2, wb_addr;
   logic [15:0] ans_ex, DM_data, A, B, wb_data;
   logic [1:0]  flag_ex, flag_reg;
   logic        wb_en;

   int tests = 0;
   int fails = 0;

   mem_wb_block dut (
      .clk(clk), .reset(reset), .valid_ex(valid_ex), .op_ex(op_ex), .rd_ex(rd_ex),
      .ans_ex(ans_ex), .DM_data(DM_data), .flag_ex(flag_ex), .rs1(rs1), .rs2(rs2),
      .A(A), .B(B), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flag_reg(flag_reg)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        en;
      logic [2:0]  addr;
      logic [15:0] data;
      logic [1:0]  fl;
      logic [15:0] a, b;
   } exp_t;

   exp_t q[$];

   // architectural model
   logic [15:0] m_regs [8];
   logic [15:0] m_mem  [256];
   logic [1:0]  m_flags;
   logic        p_en;
   logic [2:0]  p_addr;
   logic [15:0] p_data;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [5:0] op, input logic [2:0] rd,
                        input logic [15:0] ans, input logic [15:0] dm, input logic [1:0] fl);
      valid_ex = v; op_ex = op; rd_ex = rd; ans_ex = ans; DM_data = dm; flag_ex = fl;
   endtask

   task automatic nop();
      drive(1'b0, 6'd0, 3'd0, 16'h0, 16'h0, 2'b00);
   endtask

   // Issue one instruction into the stream; the expectation describes what the DUT should
   // show at the following negedge (previous instruction in writeback, reads after it).
   task automatic issue(input logic v, input logic [5:0] op, input logic [2:0] rd,
                        input logic [15:0] ans, input logic [15:0] dm, input logic [1:0] fl,
                        input logic [2:0] r1, input logic [2:0] r2);
      exp_t e;
      logic [7:0] a;
      logic alu, ld, st, wen;
      logic [15:0] wd;
      drive(v, op, rd, ans, dm, fl);
      rs1 = r1; rs2 = r2;
      e.en = p_en; e.addr = p_addr; e.data = p_data; e.fl = m_flags;
      e.a = m_regs[r1]; e.b = m_regs[r2];
      q.push_back(e);
      a   = ans[7:0];
      alu = v && op < 6'd32;
      ld  = v && op == 6'd32;
      st  = v && op == 6'd33;
      wen = (alu || ld) && rd != 3'd0;
      wd  = ld ? m_mem[a] : ans;
      if (st) m_mem[a] = dm;
      if (wen) m_regs[rd] = wd;
      if (alu) m_flags = fl;
      p_en = wen; p_addr = rd; p_data = wd;
      tick();
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("sb_wb_en", {31'd0, wb_en}, {31'd0, e.en});
         if (e.en) begin
            chk("sb_wb_addr", {29'd0, wb_addr}, {29'd0, e.addr});
            chk("sb_wb_data", {16'd0, wb_data}, {16'd0, e.data});
         end
         chk("sb_flag", {30'd0, flag_reg}, {30'd0, e.fl});
         chk("sb_A", {16'd0, A}, {16'd0, e.a});
         chk("sb_B", {16'd0, B}, {16'd0, e.b});
      end
   end

   initial begin
      reset = 0; rs1 = 0; rs2 = 0;
      nop();
      repeat (2) @(posedge clk);
      #1 reset = 1;
      #1;
      chk("rst_wb_en", {31'd0, wb_en}, 0);
      chk("rst_flag", {30'd0, flag_reg}, 0);
      for (int i = 0; i < 8; i++) begin
         rs1 = 3'(i); rs2 = 3'(7 - i);
         #1;
         chk("rst_A", {16'd0, A}, 0);
         chk("rst_B", {16'd0, B}, 0);
      end
      tick();

      // ALU write with bypass then register-file read
      drive(1, 6'd0, 3'd3, 16'h1234, 16'h0, 2'b01);
      tick();
      chk("alu_wb_en", {31'd0, wb_en}, 1);
      chk("alu_wb_addr", {29'd0, wb_addr}, 3);
      chk("alu_wb_data", {16'd0, wb_data}, 32'h1234);
      chk("alu_flag", {30'd0, flag_reg}, 1);
      rs1 = 3; #1;
      chk("alu_bypass_A", {16'd0, A}, 32'h1234);
      nop();
      tick();
      chk("alu_rf_A", {16'd0, A}, 32'h1234);

      // store then load, upper address byte ignored
      drive(1, 6'h21, 3'd0, 16'h0108, 16'hBEEF, 2'b11);
      tick();
      drive(1, 6'h20, 3'd5, 16'h0008, 16'h0, 2'b10);
      tick();
      chk("ld_wb_en", {31'd0, wb_en}, 1);
      chk("ld_wb_addr", {29'd0, wb_addr}, 5);
      chk("ld_wb_data", {16'd0, wb_data}, 32'hBEEF);
      chk("ld_flag", {30'd0, flag_reg}, 1);
      nop();
      tick();

      // R0 suppression
      drive(1, 6'd5, 3'd0, 16'hFFFF, 16'h0, 2'b10);
      tick();
      chk("r0_wb_en", {31'd0, wb_en}, 0);
      rs1 = 0; #1;
      chk("r0_A", {16'd0, A}, 0);
      chk("r0_flag", {30'd0, flag_reg}, 2);

      // NOP opcode and invalid slot
      drive(1, 6'b100010, 3'd3, 16'h5555, 16'h0, 2'b11);
      tick();
      chk("nop_wb_en", {31'd0, wb_en}, 0);
      chk("nop_flag", {30'd0, flag_reg}, 2);
      drive(0, 6'd0, 3'd3, 16'h6666, 16'h0, 2'b11);
      tick();
      chk("inv_wb_en", {31'd0, wb_en}, 0);
      chk("inv_flag", {30'd0, flag_reg}, 2);
      rs1 = 3; #1;
      chk("inv_A", {16'd0, A}, 32'h1234);

      // reset between E1 and E2 drops the pending write, memory persists
      drive(1, 6'd1, 3'd2, 16'h7777, 16'h0, 2'b11);
      tick();
      chk("pre_rst_wb_en", {31'd0, wb_en}, 1);
      #2 reset = 0;
      nop();
      @(posedge clk);
      #1 reset = 1;
      #1;
      chk("mid_rst_wb_en", {31'd0, wb_en}, 0);
      chk("mid_rst_flag", {30'd0, flag_reg}, 0);
      rs1 = 2; rs2 = 3; #1;
      chk("mid_rst_A", {16'd0, A}, 0);
      chk("mid_rst_B", {16'd0, B}, 0);
      drive(1, 6'h20, 3'd4, 16'h0108, 16'h0, 2'b00);
      tick();
      chk("persist_wb_data", {16'd0, wb_data}, 32'hBEEF);
      chk("persist_wb_en", {31'd0, wb_en}, 1);
      nop();
      tick();

      // randomized scoreboard stream from a clean reset
      reset = 0;
      tick();
      reset = 1;
      tick();
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_flags = 0; p_en = 0; p_addr = 0; p_data = 0;
      for (int i = 0; i < 16; i++)
         issue(1, 6'h21, 3'($urandom), {8'($urandom), 8'(i)}, 16'($urandom), 2'($urandom),
               3'($urandom), 3'($urandom));
      for (int n = 0; n < 400; n++) begin
         int k;
         logic v;
         logic [5:0] op;
         k = $urandom_range(0, 9);
         v = 1;
         if (k < 4)       op = 6'($urandom_range(0, 31));
         else if (k < 6) op = 6'h20;
         else if (k < 8) op = 6'h21;
         else if (k < 9) op = 6'($urandom_range(34, 63));
         else begin op = 6'($urandom); v = 0; end
         issue(v, op, 3'($urandom), {8'($urandom), 8'($urandom_range(0, 15))},
               16'($urandom), 2'($urandom), 3'($urandom), 3'($urandom));
      end
      for (int i = 0; i < 3; i++)
         issue(0, 6'd0, 3'd0, 16'h0, 16'h0, 2'b00, 3'($urandom), 3'($urandom));
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      if (q.size() > 0) chk("sb_drain", q.size(), 0);
      #20;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
